// File: rtl/network_sim_core_if.sv
// Host/control and rule-logic bundle for network_sim_core.
// The core uses the slave side; the host plus the external rule logic drive the master side.
interface network_sim_core_if #(
    parameter int RULES     = 64,
    parameter int LOG_RULES = 6,
    parameter int LOG_ITER  = 16
);
    logic                 start;
    logic [1:0]           mode;
    logic [63:0]          seed;
    logic [RULES-1:0]     init_state;
    logic [LOG_ITER-1:0]  max_iter;
    logic                 toggle_en;
    logic [LOG_ITER-1:0]  toggle_iter;
    logic [RULES-1:0]     toggle_mask;
    logic                 ld_mask;
    logic [LOG_RULES-1:0] mask_sel;
    logic                 mask_type;
    logic                 clr_masks;
    logic [RULES-1:0]     logic_in;
    logic [RULES-1:0]     network_state;
    logic [LOG_ITER-1:0]  iteration_number;
    logic                 busy;
    logic                 done;
    logic                 steady_state;
    logic                 timeout;

    modport master (
        output start, mode, seed, init_state, max_iter, toggle_en, toggle_iter,
               toggle_mask, ld_mask, mask_sel, mask_type, clr_masks, logic_in,
        input  network_state, iteration_number, busy, done, steady_state, timeout
    );

    modport slave (
        input  start, mode, seed, init_state, max_iter, toggle_en, toggle_iter,
               toggle_mask, ld_mask, mask_sel, mask_type, clr_masks, logic_in,
        output network_state, iteration_number, busy, done, steady_state, timeout
    );
endinterface

// File: rtl/network_sim_core.sv
// Network state register and update sequencer (RA / RR / SYNC) wrapped around
// an external combinational rule-logic block, with masks, toggle, cap and steady detect.
module network_sim_core #(
    parameter int RULES     = 64,
    parameter int LOG_RULES = 6,
    parameter int LOG_ITER  = 16
) (
    input  logic              clk,
    input  logic              rst,
    network_sim_core_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0]           M_RR     = 2'd1;
    localparam logic [1:0]           M_SYNC   = 2'd2;
    localparam logic [63:0]          LFSR_TAP = 64'hD800_0000_0000_0000;
    localparam logic [LOG_RULES:0]   NRULES   = (LOG_RULES+1)'(RULES);
    localparam logic [LOG_RULES-1:0] LAST     = LOG_RULES'(RULES-1);

    logic [1:0]           fsm;
    logic [RULES-1:0]     state, inhib, frc, updated;
    logic [63:0]          lfsr;
    logic [LOG_ITER-1:0]  iter;
    logic [LOG_RULES-1:0] ptr;
    logic [1:0]           mode_q;
    logic                 toggled, steady_q, timeout_q;

    logic [RULES-1:0]     eff, eff_in, state_nx, upd_nx;
    logic [LOG_ITER-1:0]  cap, iter_nx;
    logic [LOG_RULES-1:0] rule, ptr_nx;
    logic [63:0]          lfsr_nx;
    logic                 is_rr, is_sync, is_ra, rule_ok, tog_fire, adv;
    logic                 steady_hit, cap_hit;

    // Force wins over inhibit: OR the force mask in after the inhibit AND.
    assign eff     = (state & ~inhib) | frc;
    assign eff_in  = (bus.logic_in & ~inhib) | frc;
    assign cap     = (bus.max_iter == '0) ? '1 : bus.max_iter;
    assign is_rr   = (mode_q == M_RR);
    assign is_sync = (mode_q == M_SYNC);
    assign is_ra   = !is_rr && !is_sync;
    assign rule    = is_rr ? ptr : lfsr[LOG_RULES-1:0];
    assign rule_ok = ({1'b0, rule} < NRULES);
    assign tog_fire = bus.toggle_en && !toggled && (iter == bus.toggle_iter);
    assign iter_nx = iter + 1'b1;
    assign ptr_nx  = (ptr == LAST) ? '0 : ptr + 1'b1;
    assign lfsr_nx = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? LFSR_TAP : 64'h0);

    always_comb begin
        state_nx = state;
        upd_nx   = updated;
        adv      = 1'b0;
        if (tog_fire) begin
            state_nx = state ^ bus.toggle_mask;
            upd_nx   = '0;
            adv      = 1'b1;
        end else if (is_sync) begin
            state_nx = eff_in;
            adv      = 1'b1;
        end else if (rule_ok) begin
            state_nx[rule] = eff_in[rule];
            adv            = 1'b1;
            if (eff_in[rule] != eff[rule]) upd_nx = '0;
            else                           upd_nx[rule] = 1'b1;
        end
    end

    // Masked bits can never change, so they count as already updated.
    assign steady_hit = adv && (is_sync ? (!tog_fire && (eff_in == eff))
                                        : (&(upd_nx | inhib | frc)));
    assign cap_hit    = adv && (iter_nx == cap);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            state     <= '0;
            inhib     <= '0;
            frc       <= '0;
            updated   <= '0;
            lfsr      <= 64'h1;
            iter      <= '0;
            ptr       <= '0;
            mode_q    <= '0;
            toggled   <= 1'b0;
            steady_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (bus.clr_masks) begin
                        inhib <= '0;
                        frc   <= '0;
                    end else if (bus.ld_mask && ({1'b0, bus.mask_sel} < NRULES)) begin
                        if (bus.mask_type) frc[bus.mask_sel]   <= 1'b1;
                        else               inhib[bus.mask_sel] <= 1'b1;
                    end
                    if (bus.start) fsm <= S_INIT;
                end
                S_INIT: begin
                    state     <= bus.init_state;
                    lfsr      <= (bus.seed == 64'h0) ? 64'h1 : bus.seed;
                    iter      <= '0;
                    ptr       <= '0;
                    updated   <= '0;
                    mode_q    <= bus.mode;
                    toggled   <= 1'b0;
                    steady_q  <= 1'b0;
                    timeout_q <= 1'b0;
                    fsm       <= S_RUN;
                end
                S_RUN: begin
                    state   <= state_nx;
                    updated <= upd_nx;
                    if (adv) iter <= iter_nx;
                    if (tog_fire) begin
                        toggled <= 1'b1;
                    end else begin
                        if (is_ra) lfsr <= lfsr_nx;
                        if (is_rr) ptr  <= ptr_nx;
                    end
                    if (steady_hit) begin
                        steady_q <= 1'b1;
                        fsm      <= S_DONE;
                    end else if (cap_hit) begin
                        timeout_q <= 1'b1;
                        fsm       <= S_DONE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.network_state    = eff;
    assign bus.iteration_number = iter;
    assign bus.busy             = (fsm == S_INIT) || (fsm == S_RUN);
    assign bus.done             = (fsm == S_DONE);
    assign bus.steady_state     = steady_q;
    assign bus.timeout          = timeout_q;
endmodule

// File: tb/tb_network_sim_core.sv
// Directed bench: a 4-rule core for RR/SYNC/toggle/mask/reset cases and a
// 5-rule core for RA out-of-range rule selection.
module tb_network_sim_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inv4 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    network_sim_core_if #(.RULES(4), .LOG_RULES(2), .LOG_ITER(16)) bus ();
    network_sim_core_if #(.RULES(5), .LOG_RULES(3), .LOG_ITER(16)) bus5 ();

    network_sim_core #(.RULES(4), .LOG_RULES(2), .LOG_ITER(16)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    network_sim_core #(.RULES(5), .LOG_RULES(3), .LOG_ITER(16)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5));

    // External rule logic: identity or inverter on the effective state.
    assign bus.logic_in  = inv4 ? ~bus.network_state : bus.network_state;
    assign bus5.logic_in = ~bus5.network_state;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [1:0] m, input logic [3:0] init,
                         input logic [15:0] mi, input logic inv);
        bus.mode       = m;
        bus.init_state = init;
        bus.max_iter   = mi;
        bus.toggle_en  = 1'b0;
        inv4           = inv;
    endtask

    task automatic start_run();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits for DONE, checks result and that done is a single-cycle pulse.
    task automatic finish_run(input string tag, input logic [15:0] it, input logic [3:0] st,
                              input logic sty, input logic tmo);
        int n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_iter"}, bus.iteration_number, it);
        check({tag, "_state"}, bus.network_state, st);
        check({tag, "_steady"}, bus.steady_state, sty);
        check({tag, "_tmo"}, bus.timeout, tmo);
        @(negedge clk);
        check({tag, "_pulse"}, bus.done, 0);
        check({tag, "_hold"}, bus.steady_state, sty);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ns"}, bus.network_state, 0);
        check({tag, "_it"}, bus.iteration_number, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_sty"}, bus.steady_state, 0);
        check({tag, "_tmo"}, bus.timeout, 0);
    endtask

    initial begin
        bus.start = 0; bus.mode = 0; bus.seed = 64'h1; bus.init_state = 0;
        bus.max_iter = 0; bus.toggle_en = 0; bus.toggle_iter = 0; bus.toggle_mask = 0;
        bus.ld_mask = 0; bus.mask_sel = 0; bus.mask_type = 0; bus.clr_masks = 0;
        bus5.start = 0; bus5.mode = 0; bus5.seed = 64'h1; bus5.init_state = 0;
        bus5.max_iter = 0; bus5.toggle_en = 0; bus5.toggle_iter = 0; bus5.toggle_mask = 0;
        bus5.ld_mask = 0; bus5.mask_sel = 0; bus5.mask_type = 0; bus5.clr_masks = 0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        // Masks: inhibit bit 1, force bit 0 on a zero state.
        bus.ld_mask = 1; bus.mask_type = 0; bus.mask_sel = 2'd1;
        @(negedge clk);
        bus.mask_type = 1; bus.mask_sel = 2'd0;
        @(negedge clk);
        bus.ld_mask = 0;
        check("mask_idle", bus.network_state, 4'b0001);
        setup(2'd1, 4'b0010, 16'd0, 1'b0);
        start_run();
        finish_run("mask_run", 16'd4, 4'b0001, 1'b1, 1'b0);
        // Inhibit and force on bit 2: force wins.
        bus.ld_mask = 1; bus.mask_type = 0; bus.mask_sel = 2'd2;
        @(negedge clk);
        bus.mask_type = 1;
        @(negedge clk);
        bus.ld_mask = 0;
        check("force_wins", bus.network_state, 4'b0101);
        // Clear takes priority over a simultaneous load of force bit 3.
        bus.clr_masks = 1; bus.ld_mask = 1; bus.mask_type = 1; bus.mask_sel = 2'd3;
        @(negedge clk);
        bus.clr_masks = 0; bus.ld_mask = 0;
        check("clr_prio", bus.network_state, 4'b0001);

        // RR identity from 1010: steady after one sweep.
        setup(2'd1, 4'b1010, 16'd0, 1'b0);
        start_run();
        check("rr_init_busy", bus.busy, 1);
        finish_run("rr_id", 16'd4, 4'b1010, 1'b1, 1'b0);

        // SYNC inverter: never steady, stops at cap with even toggles.
        setup(2'd2, 4'b0000, 16'd10, 1'b1);
        start_run();
        finish_run("sync_cap", 16'd10, 4'b0000, 1'b0, 1'b1);

        // RR identity with toggle at iteration 2.
        setup(2'd1, 4'b0000, 16'd0, 1'b0);
        bus.toggle_en = 1; bus.toggle_iter = 16'd2; bus.toggle_mask = 4'b0011;
        start_run();
        finish_run("toggle", 16'd7, 4'b0011, 1'b1, 1'b0);

        // Steady and cap on the same edge: steady wins.
        setup(2'd1, 4'b1010, 16'd4, 1'b0);
        start_run();
        finish_run("sty_cap", 16'd4, 4'b1010, 1'b1, 1'b0);

        // Reset in the middle of an uncapped SYNC run.
        setup(2'd2, 4'b0110, 16'd0, 1'b1);
        start_run();
        repeat (5) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_rst");
        setup(2'd1, 4'b1010, 16'd0, 1'b0);
        start_run();
        finish_run("post_rst", 16'd4, 4'b1010, 1'b1, 1'b0);

        // RA on 5 rules: seed 0x1D gives rule indices 5,6,7,3,1,0.
        bus5.mode = 2'd0; bus5.seed = 64'h1D; bus5.init_state = 5'b0; bus5.max_iter = 16'd3;
        @(negedge clk);
        bus5.start = 1'b1;
        @(negedge clk);
        bus5.start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ra_noop%0d_it", k), bus5.iteration_number, 0);
            check($sformatf("ra_noop%0d_st", k), bus5.network_state, 0);
        end
        @(negedge clk);
        check("ra_first_it", bus5.iteration_number, 1);
        check("ra_first_st", bus5.network_state, 5'b01000);
        @(negedge clk);
        @(negedge clk);
        check("ra_done", bus5.done, 1);
        check("ra_it", bus5.iteration_number, 3);
        check("ra_st", bus5.network_state, 5'b01011);
        check("ra_tmo", bus5.timeout, 1);
        check("ra_sty", bus5.steady_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/network_sim_core.md
# network_sim_core

Parametrised successor to the fixed-width rule-update datapath: it holds the network state register and runs the update sequencer around an external combinational rule-logic block. It supports three update modes: random-asynchronous (RA), round-robin asynchronous (RR) and synchronous (SYNC). It also provides run-time inhibit and force masks, a run-time toggle event, an iteration cap with timeout, and steady-state detection. It sits between the top-level host/control interface and the generated `network_logic` instance.

## Interface
- `RULES`, 64: number of network elements/rules.
- `LOG_RULES`, 6: rule index width; 2^LOG_RULES >= RULES.
- `LOG_ITER`, 16: iteration counter width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled only in IDLE.
- `mode` in 2: 0 = RA, 1 = RR, 2 = SYNC, 3 = RA. Latched at start.
- `seed` in 64: LFSR seed, loaded in INIT; value 0 is replaced by 64'h1.
- `init_state` in RULES: initial network state, loaded in INIT.
- `max_iter` in LOG_ITER: iteration cap; 0 means cap at all-ones.
- `toggle_en` in 1: enable the single toggle event.
- `toggle_iter` in LOG_ITER: iteration at which the toggle fires.
- `toggle_mask` in RULES: bits XORed into the state at the toggle.
- `ld_mask` in 1: in IDLE, set one mask bit.
- `mask_sel` in LOG_RULES: bit index for `ld_mask`.
- `mask_type` in 1: 0 = inhibit (force 0), 1 = force (force 1).
- `clr_masks` in 1: in IDLE, clear both masks. Takes priority over `ld_mask`.
- `logic_in` in RULES: next-state vector from the external rule logic.
- `network_state` out RULES: effective state, (state & ~inhib) | force; this also feeds the external logic.
- `iteration_number` out LOG_ITER: completed iterations of the current or last run.
- `busy` out 1: high in INIT and RUN.
- `done` out 1: one-cycle pulse in DONE.
- `steady_state` out 1: the last run ended steady; held until the next start.
- `timeout` out 1: the last run ended at the cap; held until the next start.

## Operation
- FSM states and transitions:
  - IDLE → INIT on `start`.
  - INIT → RUN unconditionally.
  - RUN → DONE on the steady or cap condition.
  - DONE → IDLE unconditionally.
- INIT edge:
  - Load state = `init_state`, seed the LFSR, zero `iteration_number`, the RR pointer and the updated mask.
  - Latch `mode`.
  - Clear `steady_state` and `timeout`.
- Masks:
  - Written only in IDLE; `ld_mask`/`clr_masks` are ignored elsewhere.
  - If a bit is both inhibited and forced, force wins.
  - Masked bits always read as set in the updated mask.
- LFSR: 64-bit Galois, taps 64,63,61,60. Advances every RUN cycle in RA mode only.
- RA rule selection: rule = `lfsr[LOG_RULES-1:0]`. If the value is >= RULES, the cycle is a no-op: no update and no iteration increment.
- RR rule selection: the pointer steps 0..RULES-1 and wraps to 0; it advances on each evaluated rule.
- RA/RR update on a valid rule r:
  - state[r] <= effective `logic_in[r]`.
  - If the effective bit changed, the updated mask is cleared to 0; otherwise updated[r] is set.
  - `iteration_number` increments.
- SYNC update:
  - state <= effective `logic_in` every RUN cycle; `iteration_number` increments.
  - Steady when the effective `logic_in` equals `network_state` before the update.
- Toggle: in a RUN cycle with `toggle_en` and `iteration_number == toggle_iter`:
  - state <= state ^ `toggle_mask` instead of a rule update.
  - Updated mask cleared; `iteration_number` increments; RR pointer and LFSR hold.
  - Fires at most once per run.
- Steady (RA/RR): the updated mask becomes all-ones after an update edge.
- Cap: `iteration_number` reaches the cap after an update edge.
- Steady and cap on the same edge: `steady_state` = 1, `timeout` = 0.
- `rst` in any state returns everything to reset values, aborting a run. Masks clear.

## Timing
- Reset values: all outputs 0, FSM IDLE, state 0, masks 0, LFSR 64'h1.
- `start` high at edge t (in IDLE): INIT during cycle t+1 (`busy` = 1); first RUN cycle is t+2.
- One update per RUN cycle; the update is visible on `network_state` the cycle after its edge.
- Terminating edge: DONE in the following cycle, with `done` = 1, `busy` = 0 and flags valid. The next cycle is IDLE.
- `start` during INIT, RUN or DONE is ignored.
- `network_state` reflects mask changes combinationally in the cycle after the mask-write edge.

## Test plan
- RULES=4, RR, identity logic, init 4'b1010, `max_iter`=0 → steady after 4 iterations; `iteration_number`=4, `network_state`=4'b1010, `steady_state`=1, `done` pulses once.
- SYNC, logic = ~state, init 4'b0000, `max_iter`=10 → `timeout`=1, `steady_state`=0, `iteration_number`=10, `network_state`=4'b0000.
- RR, identity logic, init 0, `toggle_en`, `toggle_iter`=2, `toggle_mask`=4'b0011 → final state 4'b0011, steady at `iteration_number`=7.
- Masks: inhibit bit 1 and force bit 0 in IDLE, init 4'b0010 → `network_state`=4'b0001 before start; identity RR run ends steady at iteration 4 with 4'b0001.
- RULES=5, LOG_RULES=3, RA, seed chosen so that low bits produce 5, 6, 7 → those cycles leave state and `iteration_number` unchanged.
- `rst` asserted mid-RUN → next cycle: all outputs 0, FSM IDLE; a new start completes normally.
